// File: rtl/jacobi_rotation_sequencer.sv
// Jacobi round sequencer: streams W element pairs (and V when JACOBI_ROT_V_UPDATE_EN
// is defined) through the rotation CORDIC and writes the results back in place.
module jacobi_rotation_sequencer #(
  parameter int N               = 8,
  parameter int LOG2_N          = 3,
  parameter int N_PAIRS         = 4,
  parameter int WORD_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 7,
  parameter int V_OFFSET        = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [N_PAIRS*2*LOG2_N-1:0]      pairs_i,
  input  logic [N_PAIRS*WORD_WIDTH-1:0]    angles_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ram_en_a_o,
  output logic                             ram_we_a_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_a_o,
  output logic [WORD_WIDTH-1:0]            ram_din_a_o,
  input  logic [WORD_WIDTH-1:0]            ram_dout_a_i,
  output logic                             ram_en_b_o,
  output logic                             ram_we_b_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_b_o,
  output logic [WORD_WIDTH-1:0]            ram_din_b_o,
  input  logic [WORD_WIDTH-1:0]            ram_dout_b_i,
  output logic [WORD_WIDTH-1:0]            rotation_in_dat_x_o,
  output logic [WORD_WIDTH-1:0]            rotation_in_dat_y_o,
  output logic [WORD_WIDTH-1:0]            rotation_in_dat_z_o,
  output logic                             rotation_in_vld_o,
  input  logic [WORD_WIDTH-1:0]            rotation_fifo_out_dat_x_i,
  input  logic [WORD_WIDTH-1:0]            rotation_fifo_out_dat_y_i,
  input  logic                             rotation_fifo_out_vld_i,
  output logic                             rotation_fifo_out_rdy_o
);

  localparam int PW    = 2 * LOG2_N;
  localparam int PAIRW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int PTRW  = PAIRW + LOG2_N;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTRW-1:0] LAST = PTRW'(N_PAIRS * N - 1);
  localparam logic [OW-1:0]   OMAX = OW'(MAX_OUTSTANDING);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_W,
    S_COL_W,
    S_COL_V,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [N_PAIRS*PW-1:0]          pairs_q, pairs_d;
  logic [N_PAIRS*WORD_WIDTH-1:0]  angles_q, angles_d;
  logic [PTRW-1:0]                iss_ptr_q, iss_ptr_d;
  logic                           iss_all_q, iss_all_d;
  logic [PTRW-1:0]                wb_ptr_q, wb_ptr_d;
  logic [OW-1:0]                  outst_q, outst_d;

  logic   en_a_q, en_a_d, we_a_q, we_a_d;
  logic   en_b_q, en_b_d, we_b_q, we_b_d;
  addr_t  addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  word_t  din_a_q, din_a_d, din_b_q, din_b_d;
  logic [PAIRW-1:0] pair0_q, pair0_d;

  logic             rd1_q;
  logic [PAIRW-1:0] pair1_q;
  logic             rot_vld_q;
  word_t            rot_x_q, rot_y_q, rot_z_q;

  logic   in_pass, wb_go, iss_go, pass_end;
  state_e next_pass;
  addr_t  iss_a, iss_b, wb_a, wb_b;

  // Element address of pair p, index k for the current pass.
  function automatic addr_t elem_addr(
    input state_e                st,
    input logic [N_PAIRS*PW-1:0] prs,
    input logic [PAIRW-1:0]      p,
    input logic [LOG2_N-1:0]     k,
    input logic                  sel_j
  );
    logic [LOG2_N-1:0] idx;
    addr_t row, col, base;
    if (sel_j) idx = prs[int'(p)*PW+LOG2_N +: LOG2_N];
    else       idx = prs[int'(p)*PW +: LOG2_N];
    row  = (st == S_ROW_W) ? addr_t'(idx) : addr_t'(k);
    col  = (st == S_ROW_W) ? addr_t'(k) : addr_t'(idx);
    base = (st == S_COL_V) ? addr_t'(V_OFFSET) : '0;
    return base + (row << LOG2_N) + col;
  endfunction

  assign iss_a = elem_addr(state_q, pairs_q, iss_ptr_q[PTRW-1:LOG2_N],
                           iss_ptr_q[LOG2_N-1:0], 1'b0);
  assign iss_b = elem_addr(state_q, pairs_q, iss_ptr_q[PTRW-1:LOG2_N],
                           iss_ptr_q[LOG2_N-1:0], 1'b1);
  assign wb_a  = elem_addr(state_q, pairs_q, wb_ptr_q[PTRW-1:LOG2_N],
                           wb_ptr_q[LOG2_N-1:0], 1'b0);
  assign wb_b  = elem_addr(state_q, pairs_q, wb_ptr_q[PTRW-1:LOG2_N],
                           wb_ptr_q[LOG2_N-1:0], 1'b1);

  assign in_pass  = (state_q == S_ROW_W) || (state_q == S_COL_W) ||
                    (state_q == S_COL_V);
  assign wb_go    = in_pass & rotation_fifo_out_vld_i & (outst_q != '0);
  assign iss_go   = in_pass & ~wb_go & ~iss_all_q & (outst_q < OMAX);
  // Results return in order, so draining to zero clears cross-pass RAW hazards.
  assign pass_end = in_pass & iss_all_q & (outst_q == '0);

  always_comb begin
    next_pass = S_DONE;
    unique case (state_q)
      S_ROW_W: next_pass = S_COL_W;
`ifdef JACOBI_ROT_V_UPDATE_EN
      S_COL_W: next_pass = S_COL_V;
`else
      S_COL_W: next_pass = S_DONE;
`endif
      default: next_pass = S_DONE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pairs_d   = pairs_q;
    angles_d  = angles_q;
    iss_ptr_d = iss_ptr_q;
    iss_all_d = iss_all_q;
    wb_ptr_d  = wb_ptr_q;
    outst_d   = outst_q;
    pair0_d   = pair0_q;
    en_a_d    = 1'b0;
    we_a_d    = 1'b0;
    addr_a_d  = '0;
    din_a_d   = '0;
    en_b_d    = 1'b0;
    we_b_d    = 1'b0;
    addr_b_d  = '0;
    din_b_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ROW_W;
          pairs_d   = pairs_i;
          angles_d  = angles_i;
          iss_ptr_d = '0;
          iss_all_d = 1'b0;
          wb_ptr_d  = '0;
          outst_d   = '0;
        end
      end
      S_ROW_W, S_COL_W, S_COL_V: begin
        if (pass_end) begin
          state_d   = next_pass;
          iss_ptr_d = '0;
          iss_all_d = 1'b0;
          wb_ptr_d  = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    unique case (1'b1)
      wb_go: begin
        en_a_d   = 1'b1;
        we_a_d   = 1'b1;
        addr_a_d = wb_a;
        din_a_d  = rotation_fifo_out_dat_x_i;
        en_b_d   = 1'b1;
        we_b_d   = 1'b1;
        addr_b_d = wb_b;
        din_b_d  = rotation_fifo_out_dat_y_i;
        wb_ptr_d = wb_ptr_q + 1'b1;
        outst_d  = outst_q - 1'b1;
      end
      iss_go: begin
        en_a_d    = 1'b1;
        addr_a_d  = iss_a;
        en_b_d    = 1'b1;
        addr_b_d  = iss_b;
        pair0_d   = iss_ptr_q[PTRW-1:LOG2_N];
        iss_ptr_d = iss_ptr_q + 1'b1;
        iss_all_d = (iss_ptr_q == LAST);
        outst_d   = outst_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pairs_q   <= '0;
      angles_q  <= '0;
      iss_ptr_q <= '0;
      iss_all_q <= 1'b0;
      wb_ptr_q  <= '0;
      outst_q   <= '0;
      pair0_q   <= '0;
      en_a_q    <= 1'b0;
      we_a_q    <= 1'b0;
      addr_a_q  <= '0;
      din_a_q   <= '0;
      en_b_q    <= 1'b0;
      we_b_q    <= 1'b0;
      addr_b_q  <= '0;
      din_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      pairs_q   <= pairs_d;
      angles_q  <= angles_d;
      iss_ptr_q <= iss_ptr_d;
      iss_all_q <= iss_all_d;
      wb_ptr_q  <= wb_ptr_d;
      outst_q   <= outst_d;
      pair0_q   <= pair0_d;
      en_a_q    <= en_a_d;
      we_a_q    <= we_a_d;
      addr_a_q  <= addr_a_d;
      din_a_q   <= din_a_d;
      en_b_q    <= en_b_d;
      we_b_q    <= we_b_d;
      addr_b_q  <= addr_b_d;
      din_b_q   <= din_b_d;
    end
  end

  // Read data lands one cycle after the RAM samples; capture it with its angle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q     <= 1'b0;
      pair1_q   <= '0;
      rot_vld_q <= 1'b0;
      rot_x_q   <= '0;
      rot_y_q   <= '0;
      rot_z_q   <= '0;
    end else begin
      rd1_q     <= en_a_q & ~we_a_q;
      pair1_q   <= pair0_q;
      rot_vld_q <= rd1_q;
      if (rd1_q) begin
        rot_x_q <= ram_dout_a_i;
        rot_y_q <= ram_dout_b_i;
        rot_z_q <= angles_q[int'(pair1_q)*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign busy_o       = in_pass;
  assign done_o       = (state_q == S_DONE);
  assign ram_en_a_o   = en_a_q;
  assign ram_we_a_o   = we_a_q;
  assign ram_addr_a_o = addr_a_q;
  assign ram_din_a_o  = din_a_q;
  assign ram_en_b_o   = en_b_q;
  assign ram_we_b_o   = we_b_q;
  assign ram_addr_b_o = addr_b_q;
  assign ram_din_b_o  = din_b_q;

  assign rotation_in_vld_o       = rot_vld_q;
  assign rotation_in_dat_x_o     = rot_x_q;
  assign rotation_in_dat_y_o     = rot_y_q;
  assign rotation_in_dat_z_o     = rot_z_q;
  assign rotation_fifo_out_rdy_o = wb_go;

endmodule

// File: tb/tb_jacobi_rotation_sequencer.sv
// Bench for jacobi_rotation_sequencer: dual-port RAM model, latency-16 CORDIC
// stand-in (identity or x/y swap) feeding an in-order FIFO, directed vectors.
module tb_jacobi_rotation_sequencer;

`ifdef JACOBI_ROT_V_UPDATE_EN
  localparam int NPASS = 3;
`else
  localparam int NPASS = 2;
`endif
  localparam int EXP_IO  = 32 * NPASS;
  localparam int EXP_MAX = (NPASS == 3) ? 127 : 63;
  localparam bit V_SWAP  = (NPASS == 3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_i = 1'b0;
  logic [23:0] pairs_i = '0;
  logic [63:0] angles_i = '0;
  logic        busy_o, done_o;
  logic        ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [6:0]  ram_addr_a, ram_addr_b;
  logic [15:0] ram_din_a, ram_din_b;
  logic [15:0] dout_a, dout_b;
  logic [15:0] rot_x, rot_y, rot_z;
  logic        rot_vld;
  logic [15:0] fx, fy;
  logic        fifo_vld, fifo_rdy;

  jacobi_rotation_sequencer dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start_i                   (start_i),
    .pairs_i                   (pairs_i),
    .angles_i                  (angles_i),
    .busy_o                    (busy_o),
    .done_o                    (done_o),
    .ram_en_a_o                (ram_en_a),
    .ram_we_a_o                (ram_we_a),
    .ram_addr_a_o              (ram_addr_a),
    .ram_din_a_o               (ram_din_a),
    .ram_dout_a_i              (dout_a),
    .ram_en_b_o                (ram_en_b),
    .ram_we_b_o                (ram_we_b),
    .ram_addr_b_o              (ram_addr_b),
    .ram_din_b_o               (ram_din_b),
    .ram_dout_b_i              (dout_b),
    .rotation_in_dat_x_o       (rot_x),
    .rotation_in_dat_y_o       (rot_y),
    .rotation_in_dat_z_o       (rot_z),
    .rotation_in_vld_o         (rot_vld),
    .rotation_fifo_out_dat_x_i (fx),
    .rotation_fifo_out_dat_y_i (fy),
    .rotation_fifo_out_vld_i   (fifo_vld),
    .rotation_fifo_out_rdy_o   (fifo_rdy)
  );

  logic [101:0] out_vec;
  assign out_vec = {busy_o, done_o, ram_en_a, ram_we_a, ram_addr_a, ram_din_a,
                    ram_en_b, ram_we_b, ram_addr_b, ram_din_b,
                    rot_vld, rot_x, rot_y, rot_z, fifo_rdy};

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 301 + 7);
  endfunction

  // RAM model, 1-cycle read latency
  logic [15:0] mem [128];
  logic        ld = 1'b0;
  always @(posedge clk) begin
    if (ld) begin
      for (int a = 0; a < 128; a++) mem[a] <= pat(a);
    end else begin
      if (ram_en_a) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        else          dout_a <= mem[ram_addr_a];
      end
      if (ram_en_b) begin
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        else          dout_b <= mem[ram_addr_b];
      end
    end
  end

  // CORDIC stand-in plus output FIFO
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    int unsigned t;
  } ent_t;
  ent_t        pipe_q[$];
  ent_t        fifo_q[$];
  int unsigned cyc = 0;
  logic        swap_m = 1'b0;
  logic        hold = 1'b0;
  logic        fifo_ne = 1'b0;
  assign fifo_vld = fifo_ne & ~hold;

  always @(posedge clk) begin
    ent_t e;
    if (!rst_n) begin
      pipe_q.delete();
      fifo_q.delete();
      fifo_ne <= 1'b0;
    end else begin
      if (fifo_rdy && fifo_q.size() != 0) void'(fifo_q.pop_front());
      while (pipe_q.size() != 0 && pipe_q[0].t <= cyc)
        fifo_q.push_back(pipe_q.pop_front());
      if (rot_vld) begin
        e.x = swap_m ? rot_y : rot_x;
        e.y = swap_m ? rot_x : rot_y;
        e.t = cyc + 16;
        pipe_q.push_back(e);
      end
      fifo_ne <= (fifo_q.size() != 0);
      if (fifo_q.size() != 0) begin
        fx <= fifo_q[0].x;
        fy <= fifo_q[0].y;
      end
    end
    cyc++;
  end

  // Activity monitor
  logic        clr = 1'b1;
  logic [63:0] cur_angles = '0;
  int nrd, nwr, nin, ndone, nconf, nzbad, maxaddr, outmax;
  int wr_at [3];
  int fa [3];
  int fb [3];

  always @(negedge clk) begin
    if (clr) begin
      nrd = 0; nwr = 0; nin = 0; ndone = 0; nconf = 0; nzbad = 0;
      maxaddr = -1; outmax = 0;
      for (int i = 0; i < 3; i++) begin
        wr_at[i] = -1; fa[i] = -1; fb[i] = -1;
      end
    end else begin
      if (ram_en_a && !ram_we_a) begin
        if (nrd % 32 == 0 && nrd / 32 < 3) begin
          fa[nrd/32] = int'(ram_addr_a);
          fb[nrd/32] = int'(ram_addr_b);
        end
        if (nrd == 8)  wr_at[0] = nwr;
        if (nrd == 32) wr_at[1] = nwr;
        if (nrd == 64) wr_at[2] = nwr;
        nrd++;
      end
      if (ram_en_a && ram_we_a) nwr++;
      if (ram_en_a && int'(ram_addr_a) > maxaddr) maxaddr = int'(ram_addr_a);
      if (ram_en_b && int'(ram_addr_b) > maxaddr) maxaddr = int'(ram_addr_b);
      if (ram_en_a !== ram_en_b || ram_we_a !== ram_we_b) nconf++;
      if (nrd - nwr > outmax) outmax = nrd - nwr;
      if (rot_vld) begin
        if (rot_z !== cur_angles[((nin % 32) / 8) * 16 +: 16]) nzbad++;
        nin++;
      end
      if (done_o) ndone++;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [23:0]     pairs;
    logic [63:0]     angles;
    logic            swp;
    logic            hold;
    logic            restart;
    logic [2:0][6:0] fa;
    logic [2:0][6:0] fb;
  } vec_t;

  vec_t vecs [3];

  task automatic setup(input logic swp, input logic hld, input logic [63:0] ang);
    swap_m = swp;
    hold = hld;
    cur_angles = ang;
    ld = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1 ld = 1'b0;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] prs, input logic [63:0] ang);
    pairs_i = prs;
    angles_i = ang;
    start_i = 1'b1;
    @(negedge clk); #1;
    start_i = 1'b0;
    pairs_i = '0;
    angles_i = '0;
  endtask

  task automatic wait_done(input logic restart);
    int t;
    bit pulsed;
    t = 0;
    pulsed = 1'b0;
    while (ndone == 0 && t < 4000) begin
      @(negedge clk); #1;
      t++;
      start_i = 1'b0;
      if (restart && !pulsed && nrd >= 20) begin
        pairs_i = 24'o01234567;
        start_i = 1'b1;
        pulsed = 1'b1;
      end
    end
    start_i = 1'b0;
    pairs_i = '0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  function automatic int mem_errs(input vec_t v);
    int perm [8];
    int r, c, m;
    logic [2:0] pi, pj;
    logic [15:0] e;
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int p = 0; p < 4; p++) begin
      pi = v.pairs[p*6 +: 3];
      pj = v.pairs[p*6+3 +: 3];
      perm[pi] = int'(pj);
      perm[pj] = int'(pi);
    end
    m = 0;
    for (int a = 0; a < 128; a++) begin
      r = (a / 8) % 8;
      c = a % 8;
      if (!v.swp)     e = pat(a);
      else if (a < 64) e = pat(perm[r] * 8 + perm[c]);
      else            e = V_SWAP ? pat(64 + r * 8 + perm[c]) : pat(a);
      if (mem[a] !== e) m++;
    end
    return m;
  endfunction

  initial begin
    vecs[0] = '{24'o43526170, 64'd0, 1'b0, 1'b0, 1'b0,
                {7'd64, 7'd0, 7'd0}, {7'd71, 7'd7, 7'd56}};
    vecs[1] = '{24'o43526170, {16'd400, 16'd300, 16'd200, 16'd100},
                1'b1, 1'b0, 1'b1,
                {7'd64, 7'd0, 7'd0}, {7'd71, 7'd7, 7'd56}};
    vecs[2] = '{24'o63175024, {16'h7fff, 16'h8000, 16'd1234, 16'hfff0},
                1'b1, 1'b1, 1'b0,
                {7'd68, 7'd4, 7'd32}, {7'd66, 7'd2, 7'd16}};

    #12;
    chk("reset_outputs_ones", $countones(out_vec), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      setup(vecs[i].swp, vecs[i].hold, vecs[i].angles);
      do_start(vecs[i].pairs, vecs[i].angles);
      if (vecs[i].hold) begin
        repeat (60) @(negedge clk);
        #1;
        chk($sformatf("v%0d held_inputs", i), nin, 8);
        chk($sformatf("v%0d held_reads", i), nrd, 8);
        hold = 1'b0;
      end
      wait_done(vecs[i].restart);
      chk($sformatf("v%0d done_pulses", i), ndone, 1);
      chk($sformatf("v%0d busy_after", i), int'(busy_o), 0);
      chk($sformatf("v%0d reads", i), nrd, EXP_IO);
      chk($sformatf("v%0d writes", i), nwr, EXP_IO);
      chk($sformatf("v%0d cordic_inputs", i), nin, EXP_IO);
      chk($sformatf("v%0d max_addr", i), maxaddr, EXP_MAX);
      chk($sformatf("v%0d outst_max", i), outmax, 8);
      chk($sformatf("v%0d port_conflicts", i), nconf, 0);
      chk($sformatf("v%0d angle_errs", i), nzbad, 0);
      chk($sformatf("v%0d writes_before_read9", i), wr_at[0], 8);
      chk($sformatf("v%0d writes_before_pass2", i), wr_at[1], 32);
`ifdef JACOBI_ROT_V_UPDATE_EN
      chk($sformatf("v%0d writes_before_pass3", i), wr_at[2], 64);
`endif
      for (int p = 0; p < NPASS; p++) begin
        chk($sformatf("v%0d pass%0d first_a", i, p), fa[p], int'(vecs[i].fa[p]));
        chk($sformatf("v%0d pass%0d first_b", i, p), fb[p], int'(vecs[i].fb[p]));
      end
      chk($sformatf("v%0d mem_errs", i), mem_errs(vecs[i]), 0);
    end

    // Abort mid COL_W, then restart cleanly
    setup(1'b0, 1'b0, 64'd0);
    do_start(vecs[0].pairs, 64'd0);
    for (int t = 0; t < 3000 && nrd < 40; t++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached_colw", int'(nrd >= 40 && nrd < 64), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_ones", $countones(out_vec), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
    do_start(vecs[0].pairs, 64'd0);
    for (int t = 0; t < 50 && nrd < 1; t++) begin
      @(negedge clk); #1;
    end
    chk("restart_first_a", fa[0], 0);
    chk("restart_first_b", fb[0], 56);
    wait_done(1'b0);
    chk("restart_done_pulses", ndone, 1);
    chk("restart_reads", nrd, EXP_IO);
    chk("restart_mem_errs", mem_errs(vecs[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jacobi_rotation_sequencer.md
# jacobi_rotation_sequencer

Sequences the rotation CORDIC for one Jacobi sweep round, the step the main controller enters after angle calculation. Given four disjoint index pairs (i,j) and their angles, it streams W matrix elements out of the shared dual-port RAM into the rotation CORDIC. It writes the rotated results back in place, applying W' = R·W·Rᵀ as a row pass followed by a column pass, and optionally V' = V·Rᵀ. It owns both RAM ports while busy.

## Interface
- N, 8, matrix dimension (power of two)
- LOG2_N, 3, log2(N)
- N_PAIRS, 4, pairs per round (N/2)
- WORD_WIDTH, 16, signed data/angle width
- ADDR_WIDTH, 7, RAM address width
- V_OFFSET, 64, base address of V matrix (W base is 0)
- MAX_OUTSTANDING, 8, max issued-but-not-written-back elements (must be ≤ rotation FIFO depth)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle start; ignored while busy_o=1
- pairs_i  in  N_PAIRS·2·LOG2_N  flattened {j,i} per pair, pair 0 in LSBs; sampled on start
- angles_i  in  N_PAIRS·WORD_WIDTH  flattened angle per pair; sampled on start
- busy_o  out  1  high from cycle after start until done_o
- done_o  out  1  one-cycle pulse at end of round
- ram_en_a_o / ram_we_a_o  out  1 each  port A enable / write enable
- ram_addr_a_o  out  ADDR_WIDTH  port A address
- ram_din_a_o  out  WORD_WIDTH  port A write data
- ram_dout_a_i  in  WORD_WIDTH  port A read data, 1-cycle latency
- ram_en_b_o, ram_we_b_o, ram_addr_b_o, ram_din_b_o, ram_dout_b_i: same as port A
- rotation_in_dat_x_o / _y_o / _z_o  out  WORD_WIDTH each  element i, element j, angle
- rotation_in_vld_o  out  1  CORDIC input valid (no backpressure)
- rotation_fifo_out_dat_x_i / _y_i  in  WORD_WIDTH each  rotated element i / j
- rotation_fifo_out_vld_i  in  1  FIFO non-empty
- rotation_fifo_out_rdy_o  out  1  FIFO pop

## Operation
- States: IDLE → ROW_W → COL_W → [COL_V] → DONE → IDLE.
- Address: base + (row << LOG2_N) + col.
- Element pairs per state:
  - ROW_W: A=(i,k), B=(j,k), base 0.
  - COL_W: A=(k,i), B=(k,j), base 0.
  - COL_V: A=(k,i), B=(k,j), base V_OFFSET.
- Issue order in each pass: pair 0..N_PAIRS-1 outer, k=0..N-1 inner, giving 32 issues per pass.
- Each cycle the sequencer performs exactly one action, in priority order:
  1. Writeback, when rotation_fifo_out_vld_i=1 and outstanding>0.
     - Pop the FIFO.
     - Write x to the A address and y to the B address of the element at the writeback pointer.
     - Advance the writeback pointer.
  2. Issue, when issue items remain and outstanding<MAX_OUTSTANDING.
     - Read both ports at the issue pointer.
     - Advance the issue pointer.
  3. Otherwise no RAM access; en=0.
- Writeback pointer: a separate (pair,k) counter advanced in issue order. No address FIFO is kept, because CORDIC results return in order.
- Outstanding counter: +1 on issue, −1 on writeback, unchanged when both occur in the same cycle (impossible by priority rule).
- Pass change happens only after all 32 issued and outstanding=0. This drain is what resolves the RAW dependency between passes. Within a pass, pairs are disjoint, so there are no hazards.
- DONE asserts done_o for one cycle and clears busy_o.
- Arithmetic is pass-through; there is no width change.

## Timing
- Read issue at edge E: RAM inputs valid after E, RAM samples at E+1, dout is registered at E+2.
- rotation_in_vld_o is high in the cycle following E+2, with z = the latched angle for that pair.
- Issue throughput: one element pair per cycle when there is no writeback and no credit stall.
- rotation_fifo_out_rdy_o is combinational: rdy = vld & (outstanding>0) & busy.
- RAM write registers are driven the cycle after the pop.
- Reset (async, any state):
  - state=IDLE, all counters and pointers 0.
  - All ram_en/we outputs, rotation_in_vld_o, rotation_fifo_out_rdy_o, busy_o, done_o = 0.
  - Data/address outputs = 0.
- Reset mid-round abandons the round. Partially written RAM content is not restored.
- start_i while busy: ignored. rotation_fifo_out_vld_i with outstanding=0: never popped.

## Configuration
- JACOBI_ROT_V_UPDATE_EN defined: the COL_V pass is included, for 96 issues/writebacks per round.
- Not defined: COL_W goes directly to DONE, for 64 issues/writebacks. No address ≥ V_OFFSET is ever driven.

## Test plan
- Pairs (0,7),(1,6),(2,5),(3,4), angles 0, identity CORDIC model with latency 16, macro on -> 96 reads, 96 writes, RAM unchanged, single done_o pulse.
- Same stimulus -> first issue addresses per pass, each as A/B:
  - ROW_W: A=0, B=56.
  - COL_W: A=0, B=7.
  - COL_V: A=64, B=71.
- Also check that COL_W's first read occurs only after ROW_W's 32nd write.
- Hold FIFO vld low -> exactly 8 rotation_in_vld_o pulses, then stall. Release -> remaining issues resume and outstanding never exceeds 8.
- FIFO vld=1 in a cycle where an issue is possible -> write happens, issue slips one cycle, and no port is both read and written.
- Assert rst_n=0 mid COL_W -> all outputs take reset values the same cycle. A new start restarts at ROW_W, pair 0, k 0.
- Macro undefined -> 64 writes, max address 63, done_o after COL_W drain.
